ibex_ss_call_ret_detect: RTL and testbench

- Upstream feeder for the shadow stack. Watches the retired-instruction stream and classifies JAL/JALR as call (push), return (pop), coroutine swap (pop then push) or plain jump (nothing), following the RISC-V return-address-stack hint rules.
- For a push it drives the link address. For a pop it drives the actual jump target, which the stack compares against its stored top.
- Outputs are registered and mutually exclusive, so the stack never sees push and pop together.

---
 rtl/ibex_ss_call_ret_detect.sv | 143 ++++++++++++++
 tb/tb_ibex_ss_call_ret_detect.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_ss_call_ret_detect.sv
// Shadow-stack feeder: classifies retired JAL/JALR as call, return, coroutine swap or plain jump
// and emits registered, mutually exclusive push/pop strobes with their pointers.
module ibex_ss_call_ret_detect #(
    parameter bit ALT_LINK_EN = 1'b1,
    parameter bit RV32E       = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        enable_i,
    input  logic        retire_valid_i,
    output logic        retire_ready_o,
    input  logic [31:0] instr_i,
    input  logic        instr_compressed_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] jump_target_i,
    output logic [31:0] pointer_wr_o,
    output logic        write_indication_o,
    output logic [31:0] pointer_rd_o,
    output logic        read_indication_o
);

    typedef enum logic {
        StIdle,
        StPendPush
    } state_e;

    typedef enum logic [1:0] {
        ActNone,
        ActPush,
        ActPop,
        ActPopPush
    } action_e;

    state_e      state_q, state_d;
    action_e     action;
    logic        write_q, write_d;
    logic        read_q, read_d;
    logic [31:0] ptr_wr_q, ptr_wr_d;
    logic [31:0] ptr_rd_q, ptr_rd_d;
    logic [31:0] pend_link_q, pend_link_d;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic        rd_link;
    logic        rs1_link;
    logic [31:0] link_addr;
    logic        accept;

    // x1 and x5 exist in both register-file variants, so RV32E does not affect decode.
    logic unused_bits;
    assign unused_bits = ^{instr_i[31:20], RV32E};

    assign opcode    = instr_i[6:0];
    assign rd        = instr_i[11:7];
    assign funct3    = instr_i[14:12];
    assign rs1       = instr_i[19:15];
    assign rd_link   = (rd == 5'd1) | (ALT_LINK_EN & (rd == 5'd5));
    assign rs1_link  = (rs1 == 5'd1) | (ALT_LINK_EN & (rs1 == 5'd5));
    assign link_addr = pc_i + (instr_compressed_i ? 32'd2 : 32'd4);

    assign retire_ready_o = (state_q == StIdle);
    assign accept         = retire_valid_i & retire_ready_o;

    always_comb begin
        action = ActNone;
        if (opcode == 7'h6F) begin
            action = rd_link ? ActPush : ActNone;
        end else if (opcode == 7'h67 && funct3 == 3'd0) begin
            if (rd_link && !rs1_link) begin
                action = ActPush;
            end else if (!rd_link && rs1_link) begin
                action = ActPop;
            end else if (rd_link && rs1_link) begin
                action = (rd == rs1) ? ActPush : ActPopPush;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = 1'b0;
        read_d      = 1'b0;
        ptr_wr_d    = ptr_wr_q;
        ptr_rd_d    = ptr_rd_q;
        pend_link_d = pend_link_q;

        unique case (state_q)
            StPendPush: begin
                // The deferred push of a swap completes regardless of enable_i.
                write_d  = 1'b1;
                ptr_wr_d = pend_link_q;
                state_d  = StIdle;
            end
            default: begin
                if (accept && enable_i) begin
                    unique case (action)
                        ActPush: begin
                            write_d  = 1'b1;
                            ptr_wr_d = link_addr;
                        end
                        ActPop: begin
                            read_d   = 1'b1;
                            ptr_rd_d = jump_target_i;
                        end
                        ActPopPush: begin
                            read_d      = 1'b1;
                            ptr_rd_d    = jump_target_i;
                            pend_link_d = link_addr;
                            state_d     = StPendPush;
                        end
                        default: ;
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            write_q     <= 1'b0;
            read_q      <= 1'b0;
            ptr_wr_q    <= 32'h0;
            ptr_rd_q    <= 32'h0;
            pend_link_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            read_q      <= read_d;
            ptr_wr_q    <= ptr_wr_d;
            ptr_rd_q    <= ptr_rd_d;
            pend_link_q <= pend_link_d;
        end
    end

    assign write_indication_o = write_q;
    assign read_indication_o  = read_q;
    assign pointer_wr_o       = ptr_wr_q;
    assign pointer_rd_o       = ptr_rd_q;

endmodule

// File: tb/tb_ibex_ss_call_ret_detect.sv
// Bench for ibex_ss_call_ret_detect: table of single-retire vectors, hand-written swap, reset and
// disable sequences, and a strobe scoreboard checking order and pointers.
module tb_ibex_ss_call_ret_detect;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic        valid;
    logic [31:0] instr;
    logic        comp;
    logic [31:0] pc;
    logic [31:0] tgt;

    logic        ready, wr, rd;
    logic [31:0] ptr_wr, ptr_rd;
    logic        ready0, wr0, rd0;
    logic [31:0] ptr_wr0, ptr_rd0;

    ibex_ss_call_ret_detect #(.ALT_LINK_EN(1'b1), .RV32E(1'b0)) dut (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .enable_i           (enable),
        .retire_valid_i     (valid),
        .retire_ready_o     (ready),
        .instr_i            (instr),
        .instr_compressed_i (comp),
        .pc_i               (pc),
        .jump_target_i      (tgt),
        .pointer_wr_o       (ptr_wr),
        .write_indication_o (wr),
        .pointer_rd_o       (ptr_rd),
        .read_indication_o  (rd)
    );

    ibex_ss_call_ret_detect #(.ALT_LINK_EN(1'b0), .RV32E(1'b0)) dut_noalt (
        .clk_i              (clk),
        .rst_ni             (rst_n),
        .enable_i           (enable),
        .retire_valid_i     (valid),
        .retire_ready_o     (ready0),
        .instr_i            (instr),
        .instr_compressed_i (comp),
        .pc_i               (pc),
        .jump_target_i      (tgt),
        .pointer_wr_o       (ptr_wr0),
        .write_indication_o (wr0),
        .pointer_rd_o       (ptr_rd0),
        .read_indication_o  (rd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    typedef struct {
        bit          is_wr;
        logic [31:0] ptr;
    } ev_t;

    ev_t exp_q[$];
    bit  mon_en = 1'b0;

    task automatic expect_ev(input bit is_wr, input logic [31:0] p);
        ev_t e;
        e.is_wr = is_wr;
        e.ptr   = p;
        exp_q.push_back(e);
    endtask

    // Scoreboard: every strobe seen must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && rst_n) begin
            ev_t e;
            check("sb_exclusive", {31'b0, wr & rd}, 32'h0);
            if (rd) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_rd: unexpected pop ptr %h at %0t", ptr_rd, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_rd_kind", {31'b0, e.is_wr}, 32'h0);
                    check("sb_rd_ptr", ptr_rd, e.ptr);
                end
            end
            if (wr) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL sb_wr: unexpected push ptr %h at %0t", ptr_wr, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_wr_kind", {31'b0, e.is_wr}, 32'h1);
                    check("sb_wr_ptr", ptr_wr, e.ptr);
                end
            end
        end
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        bit          comp;
        logic [31:0] pc;
        logic [31:0] tgt;
        bit          exp_wr;
        bit          exp_rd;
        logic [31:0] exp_ptr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string n, input logic [31:0] i, input bit c,
                                input logic [31:0] p, input logic [31:0] t, input bit ew,
                                input bit er, input logic [31:0] ep);
        vec_t v;
        v.name = n; v.instr = i; v.comp = c; v.pc = p; v.tgt = t;
        v.exp_wr = ew; v.exp_rd = er; v.exp_ptr = ep;
        return v;
    endfunction

    task automatic drive(input logic [31:0] i, input bit c, input logic [31:0] p,
                         input logic [31:0] t);
        valid = 1'b1; instr = i; comp = c; pc = p; tgt = t;
    endtask

    task automatic idle_inputs();
        valid = 1'b0; instr = 32'hxxxx_xxxx; comp = 1'bx; pc = 32'hxxxx_xxxx;
        tgt = 32'hxxxx_xxxx;
    endtask

    task automatic run_vec(input vec_t v);
        @(posedge clk); #1;
        drive(v.instr, v.comp, v.pc, v.tgt);
        @(posedge clk); #1;
        idle_inputs();
        if (v.exp_rd) expect_ev(1'b0, v.exp_ptr);
        if (v.exp_wr) expect_ev(1'b1, v.exp_ptr);
        @(negedge clk);
        check({v.name, "_wr"}, {31'b0, wr}, {31'b0, v.exp_wr});
        check({v.name, "_rd"}, {31'b0, rd}, {31'b0, v.exp_rd});
        if (v.exp_wr) check({v.name, "_ptr_wr"}, ptr_wr, v.exp_ptr);
        if (v.exp_rd) check({v.name, "_ptr_rd"}, ptr_rd, v.exp_ptr);
        @(negedge clk);
        check({v.name, "_after"}, {30'b0, wr, rd}, 32'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        enable = 1'b1;
        idle_inputs();

        vecs.push_back(mk("call_x1",      32'h008000EF, 1'b0, 32'h100, 32'h0,   1, 0, 32'h104));
        vecs.push_back(mk("ret_x1",       32'h00008067, 1'b0, 32'h180, 32'h104, 0, 1, 32'h104));
        vecs.push_back(mk("jal_x0",       32'h0080006F, 1'b0, 32'h190, 32'h0,   0, 0, 32'h0));
        vecs.push_back(mk("call_x5",      32'h008002EF, 1'b0, 32'h400, 32'h0,   1, 0, 32'h404));
        vecs.push_back(mk("ret_x5",       32'h00028067, 1'b0, 32'h480, 32'h500, 0, 1, 32'h500));
        vecs.push_back(mk("jalr_x1_x1",   32'h000080E7, 1'b1, 32'h600, 32'h900, 1, 0, 32'h602));
        vecs.push_back(mk("jalr_x1_x2",   32'h000100E7, 1'b0, 32'h700, 32'h900, 1, 0, 32'h704));
        vecs.push_back(mk("jalr_f3",      32'h00009067, 1'b0, 32'h710, 32'h900, 0, 0, 32'h0));
        vecs.push_back(mk("addi",         32'h00100093, 1'b0, 32'h720, 32'h900, 0, 0, 32'h0));
        vecs.push_back(mk("jalr_x3_x2",   32'h000101E7, 1'b0, 32'h730, 32'h900, 0, 0, 32'h0));
        vecs.push_back(mk("wrap",         32'h008000EF, 1'b0, 32'hFFFF_FFFC, 32'h0, 1, 0, 32'h0));
        vecs.push_back(mk("wrap_c",       32'h008000EF, 1'b1, 32'hFFFF_FFFE, 32'h0, 1, 0, 32'h0));

        #12;
        check("rst_wr", {31'b0, wr}, 32'h0);
        check("rst_rd", {31'b0, rd}, 32'h0);
        check("rst_ptr_wr", ptr_wr, 32'h0);
        check("rst_ptr_rd", ptr_rd, 32'h0);
        check("rst_ready", {31'b0, ready}, 32'h1);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Back-to-back call, return, plain jump.
        @(posedge clk); #1;
        drive(32'h008000EF, 1'b0, 32'h100, 32'h0);
        @(posedge clk); #1;
        expect_ev(1'b1, 32'h104);
        drive(32'h00008067, 1'b0, 32'h104, 32'h104);
        @(negedge clk);
        check("b2b_call_wr", {30'b0, wr, rd}, 32'h2);
        check("b2b_call_ptr", ptr_wr, 32'h104);
        @(posedge clk); #1;
        expect_ev(1'b0, 32'h104);
        drive(32'h0080006F, 1'b0, 32'h108, 32'h0);
        @(negedge clk);
        check("b2b_ret_rd", {30'b0, wr, rd}, 32'h1);
        check("b2b_ret_ptr", ptr_rd, 32'h104);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("b2b_jal_none", {30'b0, wr, rd}, 32'h0);

        // Swap: JALR x1,0(x5) compressed, with a call held behind it.
        @(posedge clk); #1;
        drive(32'h000280E7, 1'b1, 32'h200, 32'h300);
        @(posedge clk); #1;
        expect_ev(1'b0, 32'h300);
        expect_ev(1'b1, 32'h202);
        expect_ev(1'b1, 32'h804);
        drive(32'h008000EF, 1'b0, 32'h800, 32'h0);
        @(negedge clk);
        check("swap_n1_flags", {30'b0, wr, rd}, 32'h1);
        check("swap_n1_ptr_rd", ptr_rd, 32'h300);
        check("swap_n1_ready", {31'b0, ready}, 32'h0);
        check("noalt_n1_flags", {30'b0, wr0, rd0}, 32'h2);
        check("noalt_n1_ptr_wr", ptr_wr0, 32'h202);
        @(negedge clk);
        check("swap_n2_flags", {30'b0, wr, rd}, 32'h2);
        check("swap_n2_ptr_wr", ptr_wr, 32'h202);
        check("swap_n2_ready", {31'b0, ready}, 32'h1);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("held_call_flags", {30'b0, wr, rd}, 32'h2);
        check("held_call_ptr", ptr_wr, 32'h804);
        @(negedge clk);
        check("held_call_once", {30'b0, wr, rd}, 32'h0);

        // Disabled: call retires silently.
        @(posedge clk); #1;
        enable = 1'b0;
        drive(32'h008000EF, 1'b0, 32'h100, 32'h0);
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        check("dis_none", {30'b0, wr, rd}, 32'h0);
        check("dis_ready", {31'b0, ready}, 32'h1);
        @(negedge clk);
        check("dis_none2", {30'b0, wr, rd}, 32'h0);

        // Pending push completes even after enable drops.
        @(posedge clk); #1;
        enable = 1'b1;
        drive(32'h000280E7, 1'b0, 32'hA00, 32'hB00);
        @(posedge clk); #1;
        expect_ev(1'b0, 32'hB00);
        expect_ev(1'b1, 32'hA04);
        enable = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("dis_pend_rd", {30'b0, wr, rd}, 32'h1);
        @(negedge clk);
        check("dis_pend_wr", {30'b0, wr, rd}, 32'h2);
        check("dis_pend_ptr", ptr_wr, 32'hA04);

        // Reset while the push is pending: nothing comes out afterwards.
        @(posedge clk); #1;
        enable = 1'b1;
        drive(32'h000280E7, 1'b0, 32'hC00, 32'hD00);
        @(posedge clk); #1;
        idle_inputs();
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_pend_flags", {30'b0, wr, rd}, 32'h0);
        check("rst_pend_ready", {31'b0, ready}, 32'h1);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_flags", {30'b0, wr, rd}, 32'h0);
        check("post_rst_ready", {31'b0, ready}, 32'h1);
        @(negedge clk);
        check("post_rst_flags2", {30'b0, wr, rd}, 32'h0);

        repeat (2) @(negedge clk);
        check("sb_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
